uart_rx_en: RTL and testbench
=============================

# uart_rx_en

Oversampled 8N1 UART receiver, the receive-side counterpart of the enable-strobed UART transmitter. It synchronises the serial line, detects and validates a start bit, and samples 8 data bits LSB-first plus one stop bit at mid-bit. It presents each received byte with a one-cycle `done` pulse, or flags a framing error. All timing is driven by an external oversample strobe `en` from the shared baud generator, so one baud generator serves both directions.

## Interface

- `OVERSAMPLE`, default 16: `en` ticks per bit period. Must be even and ≥ 4. Tick counter width is `$clog2(OVERSAMPLE)`.
- `clk` input, 1 bit: clock.
- `nReset` input, 1 bit: reset, asynchronous, active-low.
- `en` input, 1 bit: oversample strobe. High for one `clk` cycle per tick (`OVERSAMPLE` ticks per bit).
- `in` input, 1 bit: asynchronous serial line. Idle high.
- `data` output, 8 bits: last correctly framed byte. Held until the next good frame.
- `done` output, 1 bit: one-`clk` pulse when `data` is updated.
- `err` output, 1 bit: one-`clk` pulse on a framing error (stop bit sampled 0).
- `busy` output, 1 bit: high while state ≠ IDLE.

## Operation

- **Input path**
  - `in` passes through a 2-flop synchroniser (both flops reset to 1); all sampling uses the synchronised value `rxIn`.
  - The state machine and tick counter advance only on cycles with `en`=1. With `en`=0, all state, counters and the shift register hold.
- **States**: IDLE, START, DATA, STOP. Registered. On reset, state = IDLE.
- **IDLE**
  - On an `en` tick with `rxIn`=0: go to START, clear tick counter.
  - Otherwise stay in IDLE.
- **START**
  - Count ticks. On the (`OVERSAMPLE`/2)-th tick after entry, sample `rxIn`.
  - Sample 0: go to DATA, clear counter and bit count.
  - Sample 1: glitch. Return to IDLE with no `done` and no `err`.
- **DATA**
  - On every `OVERSAMPLE`-th tick: sample `rxIn`, shift it into the shift register MSB side (`shift <= {rxIn, shift[7:1]}`), increment the 3-bit bit count.
  - After the 8th sample, go to STOP with the counter cleared.
- **STOP**
  - On the `OVERSAMPLE`-th tick: sample `rxIn`, then go to IDLE.
  - Sample 1: `data <= shift`; `done` is high the next cycle.
  - Sample 0: `err` is high the next cycle; `data` is unchanged.
- **Idle hunting**: the stop bit is sampled at mid-bit, so IDLE resumes hunting for the next start edge during the second half of the stop bit. A start bit immediately following the stop bit is received.
- **Outputs**: `done`, `err` and `data` are registered. `done` and `err` are never high together.
- **Break**: a continuously low line yields `err` after each 10-bit frame, then re-enters START on the next tick.

## Timing

- **Reset values**: `data`=0x00, `done`=0, `err`=0, `busy`=0, state = IDLE, synchroniser = 1.
- **Synchroniser latency**: a change on `in` reaches `rxIn` 2 `clk` cycles later.
- **Frame latency**:
  - Count from the tick that leaves IDLE. The stop sample occurs `OVERSAMPLE`/2 + 9·`OVERSAMPLE` ticks later (152 ticks for `OVERSAMPLE`=16).
  - `done`/`err` rise on the clock edge after the stop-sample tick and fall one cycle later, regardless of `en`.
- **`busy` timing**: `busy` rises the cycle after the IDLE→START tick and falls the cycle after the stop-sample tick, in the same cycle `done`/`err` rise.
- **Reset mid-frame**: asynchronous return to the reset values. The partial byte is discarded and no `done`/`err` is produced.
- **`en` gaps**: arbitrary gaps between ticks only stretch the timing. There is no timeout.

## Test plan

- **Nominal frame**: `OVERSAMPLE`=16, `en`=1 every cycle, send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first) at 16 cycles/bit -> one `done` pulse, `data`=0xA5, `err`=0, `busy` low after the frame.
- **Start glitch**: `in` low for 4 ticks, then high -> START aborts at tick 8, back to IDLE, no `done`/`err`, `data` unchanged (0x00 after reset).
- **Framing error**: receive 0x3C, then send 0x7E with stop bit = 0 -> `err` pulse for exactly 1 cycle, no `done`, `data` stays 0x3C.
- **Sparse `en`**: `en` high every 3rd cycle, line timed to 48 `clk`/bit, send 0xC3 -> `data`=0xC3 with a single `done`. Hold `en` low for 20 cycles mid-byte (line timing stretched to match) -> same result.
- **Back-to-back and loopback**: send 0x00 then 0xFF with no idle gap -> two `done` pulses, `data` 0x00 then 0xFF. Loop the transmitter's output (its `en` = rx `en`/16) for bytes 0x01, 0x80, 0x55 -> all received correctly.
- **Reset mid-frame**: assert `nReset` during data bit 4 of 0x5A -> all outputs go to reset values immediately. After release, a full 0x96 frame -> `data`=0x96, one `done`.

Source files
------------

// File: rtl/uart_rx_en_if.sv
// Serial-receive bundle: oversample strobe and line in, received byte and status out.
`timescale 1ns/1ps
interface uart_rx_en_if;
  logic       en;
  logic       in;
  logic [7:0] data;
  logic       done;
  logic       err;
  logic       busy;

  modport master (output en, in, input  data, done, err, busy);
  modport slave  (input  en, in, output data, done, err, busy);
endinterface

// File: rtl/uart_rx_en.sv
// Oversampled 8N1 UART receiver, timed entirely by the shared baud strobe en.
`timescale 1ns/1ps
module uart_rx_en #(
  parameter int OVERSAMPLE = 16
) (
  input logic        clk,
  input logic        nReset,
  uart_rx_en_if.slave bus
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [1:0]    sync;
  logic          rxIn;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bitcnt, bitcnt_nx;
  logic [7:0]    shift, shift_nx, data_q, data_nx;
  logic          done_q, done_nx, err_q, err_nx;

  // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) sync <= 2'b11;
    else         sync <= {sync[0], bus.in};

  assign rxIn = sync[1];

  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      state  <= IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      shift  <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      bitcnt <= bitcnt_nx;
      shift  <= shift_nx;
      data_q <= data_nx;
      done_q <= done_nx;
      err_q  <= err_nx;
    end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    bitcnt_nx = bitcnt;
    shift_nx  = shift;
    data_nx   = data_q;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    if (bus.en) begin
      unique case (state)
        IDLE:
          if (!rxIn) begin
            state_nx = START;
            cnt_nx   = '0;
          end
        // Mid start-bit check rejects glitches shorter than half a bit.
        START:
          if (cnt == HALF) begin
            cnt_nx = '0;
            if (rxIn) state_nx = IDLE;
            else begin
              state_nx  = DATA;
              bitcnt_nx = '0;
            end
          end else cnt_nx = cnt + 1'b1;
        DATA:
          if (cnt == FULL) begin
            cnt_nx    = '0;
            shift_nx  = {rxIn, shift[7:1]};
            bitcnt_nx = bitcnt + 3'd1;
            if (bitcnt == 3'd7) state_nx = STOP;
          end else cnt_nx = cnt + 1'b1;
        // Leaving at mid stop-bit lets IDLE catch a start bit right behind it.
        STOP:
          if (cnt == FULL) begin
            cnt_nx   = '0;
            state_nx = IDLE;
            if (rxIn) begin
              data_nx = shift;
              done_nx = 1'b1;
            end else err_nx = 1'b1;
          end else cnt_nx = cnt + 1'b1;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign bus.data = data_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_en.sv
// Directed plus random frames against a byte-level model of the 8N1 receiver.
`timescale 1ns/1ps
module tb_uart_rx_en;
  localparam int OS = 16;

  logic clk = 1'b0;
  logic nReset;
  uart_rx_en_if u();

  uart_rx_en #(.OVERSAMPLE(OS)) dut (.clk(clk), .nReset(nReset), .bus(u));

  always #5 clk = ~clk;

  int  div = 1;
  bit  hold = 1'b0;
  int  checks = 0, passes = 0, fails = 0;
  int  done_cnt = 0, err_cnt = 0, first_lat = -1, cmp_idx = 0;
  int  cyc = 0, t_busy = 0;
  logic first_busy = 1'bx, busy_q = 1'b0;
  bit  both = 1'b0;
  logic [7:0] got_q[$], exp_q[$];
  logic [7:0] last_good = 8'h00;
  int  exp_err = 0;

  // en strobe: one tick every div cycles, frozen (phase included) while hold is set
  initial begin
    int phase = 0;
    u.en = 1'b0;
    forever begin
      @(negedge clk);
      if (hold) u.en = 1'b0;
      else begin
        u.en  = (phase == 0);
        phase = (phase + 1 >= div) ? 0 : phase + 1;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u.busy && !busy_q) t_busy = cyc;
    busy_q = u.busy;
    if (u.done) begin
      if (done_cnt == 0) begin
        first_lat  = cyc - t_busy;
        first_busy = u.busy;
      end
      done_cnt++;
      got_q.push_back(u.data);
    end
    if (u.err) err_cnt++;
    if (u.done && u.err) both = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bit_time(input logic v, input int n);
    u.in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    bit_time(1'b1, n * OS * div);
  endtask

  // Serialise start, 8 data LSB-first, stop; optionally freeze en for 20 cycles mid bit hold_bit.
  task automatic send_frame(input logic [7:0] b, input logic stopb, input int hold_bit);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i == hold_bit) begin
        u.in = f[i];
        repeat (OS*div/2) @(negedge clk);
        hold = 1'b1;
        repeat (20) @(negedge clk);
        hold = 1'b0;
        repeat (OS*div - OS*div/2) @(negedge clk);
      end else bit_time(f[i], OS*div);
    end
    u.in = 1'b1;
    if (stopb) begin
      exp_q.push_back(b);
      last_good = b;
    end else exp_err++;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".done"}, done_cnt, exp_q.size());
    check({tag, ".err"},  err_cnt, exp_err);
    check({tag, ".data"}, u.data, last_good);
    check({tag, ".busy"}, u.busy, 1'b0);
    if (got_q.size() == exp_q.size()) begin
      for (int i = cmp_idx; i < exp_q.size(); i++)
        check({tag, ".byte"}, got_q[i], exp_q[i]);
      cmp_idx = exp_q.size();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] f;
    logic [7:0] b;
    logic       sb;
    nReset = 1'b0;
    u.in   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.data", u.data, 8'h00);
    check("rst.done", u.done, 1'b0);
    check("rst.err",  u.err,  1'b0);
    check("rst.busy", u.busy, 1'b0);
    nReset = 1'b1;
    idle_bits(2);

    // start glitch: 4 cycles low
    bit_time(1'b0, 4);
    idle_bits(2);
    check_all("glitch");

    // nominal frame with exact latency
    send_frame(8'hA5, 1'b1, -1);
    idle_bits(2);
    check_all("nominal");
    check("latency", first_lat, OS/2 + 9*OS);
    check("busy_at_done", first_busy, 1'b0);

    // framing error keeps previous byte
    send_frame(8'h3C, 1'b1, -1);
    send_frame(8'h7E, 1'b0, -1);
    idle_bits(2);
    check_all("frame_err");

    // sparse en, then with a 20-cycle en gap mid-byte
    div = 3;
    idle_bits(1);
    send_frame(8'hC3, 1'b1, -1);
    idle_bits(2);
    check_all("sparse");
    send_frame(8'hC3, 1'b1, 4);
    idle_bits(2);
    check_all("en_gap");

    // back-to-back, then transmitter-style bytes
    div = 1;
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    idle_bits(2);
    check_all("b2b");
    send_frame(8'h01, 1'b1, -1);
    idle_bits(1);
    send_frame(8'h80, 1'b1, -1);
    idle_bits(1);
    send_frame(8'h55, 1'b1, -1);
    idle_bits(2);
    check_all("loop");

    // random frames, rates, stop bits and gaps
    for (int k = 0; k < 10; k++) begin
      div = $urandom_range(1, 3);
      b   = 8'($urandom);
      sb  = ($urandom_range(0, 3) != 0);
      send_frame(b, sb, -1);
      idle_bits(sb ? $urandom_range(0, 2) : $urandom_range(1, 2));
    end
    idle_bits(2);
    check_all("random");

    // reset during data bit 4 of 0x5A
    div = 1;
    idle_bits(1);
    f = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 5; i++) bit_time(f[i], OS);
    u.in = f[5];
    repeat (OS/2) @(negedge clk);
    check("mid.busy", u.busy, 1'b1);
    #2 nReset = 1'b0;
    #1;
    check("mid.rst.data", u.data, 8'h00);
    check("mid.rst.busy", u.busy, 1'b0);
    check("mid.rst.done", u.done, 1'b0);
    check("mid.rst.err",  u.err,  1'b0);
    last_good = 8'h00;
    u.in = 1'b1;
    repeat (5) @(negedge clk);
    nReset = 1'b1;
    idle_bits(3);
    send_frame(8'h96, 1'b1, -1);
    idle_bits(2);
    check_all("after_rst");

    check("done_err_excl", both, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
